// File: rtl/mac_pkg.sv
// Purpose: shared types and the saturating add helper for the dot-product MAC (sat_add is used when MAC_DOT_SAT_EN is defined).
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package mac_pkg;

    // Per-beat operand signedness; travels with the beat into the multipliers.
    typedef struct packed {
        logic a_signed;
        logic b_signed;
    } mac_mode_t;

    // Framing and mode carried by each input beat.
    typedef struct packed {
        logic      first;
        logic      last;
        mac_mode_t mode;
    } mac_beat_t;

    // Widest accumulator the saturating helper supports.
    localparam int SAT_MAX_W = 64;

    // Signed add of the low 'width' bits of a and b, clamped to the signed
    // range of 'width' bits on overflow. Only the low 'width' bits of the
    // return value are meaningful.
    function automatic logic [SAT_MAX_W-1:0] sat_add(
        input logic [SAT_MAX_W-1:0] a,
        input logic [SAT_MAX_W-1:0] b,
        input int                   width
    );
        logic [SAT_MAX_W-1:0] s;
        logic [SAT_MAX_W-1:0] max_pos;
        logic [5:0]           msb;
        msb     = 6'(width - 1);
        s       = a + b;
        max_pos = (64'd1 << msb) - 64'd1;
        if ((a[msb] == b[msb]) && (s[msb] != a[msb])) begin
            // ~max_pos has 1 at msb and zeros below: the most negative value.
            return a[msb] ? ~max_pos : max_pos;
        end
        return s;
    endfunction

endpackage

// File: rtl/mac_lane_mul.sv
// Purpose: one lane multiply; each operand is widened by one bit, sign- or zero-extended per its mode flag.
// Latency: combinational.
// Backpressure: none; the parent registers the product.
module mac_lane_mul #(
    parameter int A_W = 8,
    parameter int B_W = 8
) (
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    input  logic               a_signed,
    input  logic               b_signed,
    output logic [A_W+B_W+1:0] p
);
    localparam int PW = A_W + B_W + 2;

    logic          a_pad;
    logic          b_pad;
    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;

    assign a_pad = a_signed & a[A_W-1];
    assign b_pad = b_signed & b[B_W-1];

    // Both operands are extended to the full product width, so the low PW
    // bits of a plain multiply are exactly the two's-complement product.
    assign a_ext = {{(PW-A_W){a_pad}}, a};
    assign b_ext = {{(PW-B_W){b_pad}}, b};
    assign p     = a_ext * b_ext;

endmodule

// File: rtl/mac_dot_unit.sv
// Purpose: LANES-wide dot product per beat, accumulated over a first..last frame; MAC_DOT_SAT_EN selects saturating accumulate.
// Latency: beat accepted in cycle t with last set gives out_valid_o in cycle t+2.
// Backpressure: in_ready_o drops while a result waits unconsumed; the whole pipeline then holds.
module mac_dot_unit
    import mac_pkg::*;
#(
    parameter int LANES = 4,
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int ACC_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 in_first_i,
    input  logic                 in_last_i,
    input  logic                 a_signed_i,
    input  logic                 b_signed_i,
    input  logic [LANES*A_W-1:0] a_i,
    input  logic [LANES*B_W-1:0] b_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [ACC_W-1:0]     acc_o,
    output logic                 ovf_o
);
    localparam int PW  = A_W + B_W + 2;
    localparam int MSB = ACC_W - 1;

    logic             stall;
    mac_beat_t        beat_in;
    logic [PW-1:0]    prod [LANES];
    logic [ACC_W-1:0] lane_sum;

    logic             s1_vld;
    logic             s1_first;
    logic             s1_last;
    logic [ACC_W-1:0] s1_sum;

    logic [ACC_W-1:0] acc;
    logic             ovf_acc;
    logic             fresh;

    logic             start;
    logic [ACC_W-1:0] add_wrap;
    logic [ACC_W-1:0] add_res;
    logic [ACC_W-1:0] acc_next;
    logic             add_ovf;
    logic             ovf_next;

    // A result that nobody takes freezes every stage.
    assign stall      = out_valid_o && !out_ready_i;
    assign in_ready_o = !stall;

    assign beat_in = '{first: in_first_i, last: in_last_i,
                       mode: '{a_signed: a_signed_i, b_signed: b_signed_i}};

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        mac_lane_mul #(.A_W(A_W), .B_W(B_W)) u_mul (
            .a        (a_i[k*A_W +: A_W]),
            .b        (b_i[k*B_W +: B_W]),
            .a_signed (beat_in.mode.a_signed),
            .b_signed (beat_in.mode.b_signed),
            .p        (prod[k])
        );
    end

    // Sum of the lane products, each sign-extended to the accumulator width.
    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum = lane_sum + ACC_W'($signed(prod[k]));
        end
    end

    // A starting beat (explicit first, or any beat after a last or reset)
    // replaces the accumulator and clears the sticky overflow.
    assign start    = s1_first || fresh;
    assign add_wrap = acc + s1_sum;
    assign add_ovf  = (acc[MSB] == s1_sum[MSB]) && (add_wrap[MSB] != acc[MSB]);

`ifdef MAC_DOT_SAT_EN
    assign add_res = ACC_W'(sat_add(SAT_MAX_W'(acc), SAT_MAX_W'(s1_sum), ACC_W));
`else
    assign add_res = add_wrap;
`endif

    assign acc_next = start ? s1_sum : add_res;
    assign ovf_next = start ? 1'b0 : (ovf_acc | add_ovf);

    // Stage 1: register the lane sum and framing of each accepted beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_sum   <= '0;
        end else if (!stall) begin
            s1_vld <= in_valid_i;
            if (in_valid_i) begin
                s1_first <= beat_in.first;
                s1_last  <= beat_in.last;
                s1_sum   <= lane_sum;
            end
        end
    end

    // Stage 2: accumulate, track sticky overflow, re-arm fresh after a last beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc     <= '0;
            ovf_acc <= 1'b0;
            fresh   <= 1'b1;
        end else if (!stall && s1_vld) begin
            acc     <= acc_next;
            ovf_acc <= ovf_next;
            fresh   <= s1_last;
        end
    end

    // Output register: loads on a last beat (even while popping), clears on pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_o <= 1'b0;
            acc_o       <= '0;
            ovf_o       <= 1'b0;
        end else if (!stall) begin
            if (s1_vld && s1_last) begin
                out_valid_o <= 1'b1;
                acc_o       <= acc_next;
                ovf_o       <= ovf_next;
            end else begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule
